// File: rtl/sysop_issue.sv
// SYSTEM-class instruction issue: decodes CSR/ecall/ebreak/xRET/wfi, drives one
// command cycle to the CSR unit, then returns writeback and redirect pulses.
module sysop_issue #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic            flush,
    output logic [XLEN-1:0] pc,
    output logic [4:0]      op,
    output logic [XLEN-1:0] tval,
    output logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    input  logic            r_valid,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [1:0]      priv,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            redirect_en,
    output logic [XLEN-1:0] redirect_pc,
    output logic            illegal_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    localparam logic [4:0] OP_NOP  = 5'h00;
    localparam logic [4:0] OP_RET  = 5'h01;
    localparam logic [4:0] OP_ILL  = 5'h12;
    localparam logic [4:0] OP_EBRK = 5'h13;

    // Instructions whose final op depends on privilege are tagged at acceptance
    // and resolved in ISSUE, where priv is sampled.
    localparam logic [1:0] K_PLAIN = 2'd0;
    localparam logic [1:0] K_ECALL = 2'd1;
    localparam logic [1:0] K_MRET  = 2'd2;
    localparam logic [1:0] K_SRET  = 2'd3;

    state_t          state_reg;
    logic [XLEN-1:0] pc_reg;
    logic [4:0]      rd_reg;
    logic [4:0]      op_reg;
    logic [1:0]      kind_reg;
    logic [XLEN-1:0] tval_reg;
    logic [XLEN-1:0] wdata_reg;
    logic [XLEN-1:0] rdata_reg;
    logic [XLEN-1:0] trap_pc_reg;
    logic            wb_pend_reg;
    logic            redir_pend_reg;

    logic [4:0]      dec_op;
    logic [1:0]      dec_kind;
    logic [XLEN-1:0] dec_tval;
    logic [XLEN-1:0] dec_wdata;
    logic [2:0]      f3;
    logic [4:0]      iss_op;
    logic [XLEN-1:0] iss_tval;
    logic [3:0]      ecall_cause;
    logic            in_issue;
    logic            in_done;
    logic            accept;

    assign f3 = in_inst[14:12];

    always_comb begin
        dec_op    = OP_ILL;
        dec_kind  = K_PLAIN;
        dec_tval  = {{(XLEN-32){1'b0}}, in_inst};
        dec_wdata = '0;
        if (in_inst[6:0] == 7'b1110011) begin
            case (f3)
                3'b001, 3'b010, 3'b011: begin
                    dec_op    = {3'b000, f3[1:0]} + 5'd1;
                    dec_tval  = {{(XLEN-12){1'b0}}, in_inst[31:20]};
                    dec_wdata = in_rs1_data;
                end
                3'b101, 3'b110, 3'b111: begin
                    dec_op    = {3'b000, f3[1:0]} + 5'd1;
                    dec_tval  = {{(XLEN-12){1'b0}}, in_inst[31:20]};
                    dec_wdata = {{(XLEN-5){1'b0}}, in_inst[19:15]};
                end
                3'b000: begin
                    case (in_inst[31:20])
                        12'h000: begin
                            dec_kind = K_ECALL;
                            dec_op   = OP_NOP;
                            dec_tval = '0;
                        end
                        12'h001: begin
                            dec_op   = OP_EBRK;
                            dec_tval = in_pc;
                        end
                        12'h302: dec_kind = K_MRET;
                        12'h102: dec_kind = K_SRET;
                        12'h105: begin
                            dec_op   = OP_NOP;
                            dec_tval = '0;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ecall_cause = (priv == 2'd0) ? 4'd8 : (priv == 2'd1) ? 4'd9 : 4'd11;
        iss_op      = op_reg;
        iss_tval    = tval_reg;
        case (kind_reg)
            K_ECALL: iss_op = {1'b1, ecall_cause};
            K_MRET: if (priv == 2'd3) begin
                iss_op   = OP_RET;
                iss_tval = '0;
            end
            K_SRET: if (priv != 2'd0) begin
                iss_op   = OP_RET;
                iss_tval = '0;
            end
            default: ;
        endcase
    end

    assign in_issue    = (state_reg == ISSUE);
    assign in_done     = (state_reg == DONE);
    assign in_ready    = (state_reg == IDLE);
    assign accept      = in_valid && in_ready && !flush;

    assign op          = (in_issue && !flush) ? iss_op : OP_NOP;
    assign pc          = in_issue ? pc_reg : '0;
    assign tval        = in_issue ? iss_tval : '0;
    assign wdata       = in_issue ? wdata_reg : '0;
    assign illegal_o   = in_issue && !flush && (iss_op == OP_ILL);

    assign wb_valid    = in_done && wb_pend_reg && (rd_reg != 5'd0) && !flush;
    assign wb_rd       = rd_reg;
    assign wb_data     = rdata_reg;
    assign redirect_en = in_done && redir_pend_reg && !flush;
    assign redirect_pc = trap_pc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            pc_reg         <= '0;
            rd_reg         <= '0;
            op_reg         <= OP_NOP;
            kind_reg       <= K_PLAIN;
            tval_reg       <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
            trap_pc_reg    <= '0;
            wb_pend_reg    <= 1'b0;
            redir_pend_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (accept) begin
                    state_reg      <= ISSUE;
                    pc_reg         <= in_pc;
                    rd_reg         <= in_inst[11:7];
                    op_reg         <= dec_op;
                    kind_reg       <= dec_kind;
                    tval_reg       <= dec_tval;
                    wdata_reg      <= dec_wdata;
                    wb_pend_reg    <= 1'b0;
                    redir_pend_reg <= 1'b0;
                end
                ISSUE: begin
                    state_reg <= DONE;
                    if (r_valid) rdata_reg <= rdata;
                    if (trap_en) trap_pc_reg <= trap_pc;
                    // A flushed command must not complete, whatever the CSR unit said.
                    wb_pend_reg    <= r_valid && !flush;
                    redir_pend_reg <= trap_en && !flush;
                end
                DONE: begin
                    state_reg      <= IDLE;
                    wb_pend_reg    <= 1'b0;
                    redir_pend_reg <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
